// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared widths, default oversample ratio and run state for the UART baud generator
package uart_pkg;

    localparam int UART_DIV_W            = 16;
    localparam int UART_OS_W             = 5;
    localparam int UART_FRAC_W           = 4;
    localparam int UART_OS_RATIO_DEFAULT = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } baud_state_e;

endpackage

// File: rtl/uart_prescaler.sv
// rtl/uart_prescaler.sv - prescale counter producing os_tick; UART_BAUD_FRAC_EN adds the fractional accumulator
module uart_prescaler
    import uart_pkg::*;
#(
    parameter int DIV_W  = UART_DIV_W
`ifdef UART_BAUD_FRAC_EN
    ,
    parameter int FRAC_W = UART_FRAC_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              count,
    input  logic [DIV_W-1:0]  n_m1,
`ifdef UART_BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac,
`endif
    output logic              os_wrap,
    output logic              os_tick
);

    logic [DIV_W-1:0] pcnt_q, pcnt_d;
    logic             os_tick_q, os_tick_d;
    logic [DIV_W-1:0] limit;

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;

    // A carry out of the accumulator stretches the following period by one clk.
    assign limit = n_m1 + DIV_W'(ext_q);

    always_comb begin
        acc_d = acc_q;
        ext_d = ext_q;
        if (!count) begin
            acc_d = '0;
            ext_d = 1'b0;
        end else if (os_wrap) begin
            {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, frac};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            ext_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ext_q <= ext_d;
        end
    end
`else
    assign limit = n_m1;
`endif

    assign os_wrap = count && (pcnt_q == limit);

    always_comb begin
        pcnt_d    = pcnt_q + DIV_W'(1);
        if (!count || os_wrap) begin
            pcnt_d = '0;
        end
        os_tick_d = os_wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q    <= '0;
            os_tick_q <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            os_tick_q <= os_tick_d;
        end
    end

    assign os_tick = os_tick_q;

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - UART oversample/mid-bit/bit strobe generator; UART_BAUD_FRAC_EN enables fractional divisor
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W  = UART_DIV_W,
    parameter int OS_W   = UART_OS_W,
    parameter int FRAC_W = UART_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    input  logic [OS_W-1:0]   os_ratio,
`ifdef UART_BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac,
`endif
    input  logic              resync,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick
);

    if (DIV_W < 1 || OS_W < 2 || FRAC_W < 1) begin : g_param_check
        $error("uart_baud_gen: invalid parameter widths");
    end

    baud_state_e       state_q, state_d;
    logic [DIV_W-1:0]  n_m1_q, n_m1_d;
    logic [OS_W-1:0]   r_m1_q, r_m1_d;
    logic [OS_W-1:0]   oscnt_q, oscnt_d;
    logic              mid_tick_q, mid_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              count, os_wrap, bit_wrap, mid_hit, load;
    logic [OS_W-1:0]   r_half;

    // resync suppresses counting so the realigning edge itself emits no strobe.
    assign count    = (state_q == ST_RUN) && en && !resync;
    assign r_half   = (r_m1_q + OS_W'(1)) >> 1;
    assign bit_wrap = os_wrap && (oscnt_q == r_m1_q);
    assign mid_hit  = os_wrap && ((r_half == '0) ? (oscnt_q == r_m1_q)
                                                 : (oscnt_q == r_half - OS_W'(1)));
    assign load     = en && ((state_q == ST_IDLE) || resync || bit_wrap);

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_q, frac_d;

    always_comb begin
        frac_d = frac_q;
        if (load) begin
            frac_d = frac;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frac_q <= '0;
        end else begin
            frac_q <= frac_d;
        end
    end
`endif

    uart_prescaler #(
        .DIV_W  (DIV_W)
`ifdef UART_BAUD_FRAC_EN
        ,
        .FRAC_W (FRAC_W)
`endif
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .count   (count),
        .n_m1    (n_m1_q),
`ifdef UART_BAUD_FRAC_EN
        .frac    (frac_q),
`endif
        .os_wrap (os_wrap),
        .os_tick (os_tick)
    );

    always_comb begin
        state_d = en ? ST_RUN : ST_IDLE;
        n_m1_d  = n_m1_q;
        r_m1_d  = r_m1_q;
        // Shadows hold N-1 and R-1 with zero already mapped to one.
        if (load) begin
            n_m1_d = (div == '0) ? '0 : div - DIV_W'(1);
            r_m1_d = (os_ratio == '0) ? '0 : os_ratio - OS_W'(1);
        end
        oscnt_d = oscnt_q;
        if (!count || bit_wrap) begin
            oscnt_d = '0;
        end else if (os_wrap) begin
            oscnt_d = oscnt_q + OS_W'(1);
        end
        mid_tick_d = mid_hit;
        bit_tick_d = bit_wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            n_m1_q     <= '0;
            r_m1_q     <= '0;
            oscnt_q    <= '0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_m1_q     <= n_m1_d;
            r_m1_q     <= r_m1_d;
            oscnt_q    <= oscnt_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign mid_tick = mid_tick_q;
    assign bit_tick = bit_tick_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - self-checking bench for uart_baud_gen against a time-based strobe model
module tb_uart_baud_gen;

    localparam int DIV_W  = 16;
    localparam int OS_W   = 5;
    localparam int FRAC_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             resync = 1'b0;
    logic [DIV_W-1:0] div = '0;
    logic [OS_W-1:0]  os_ratio = '0;
`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac = '0;
`endif
    logic             os_tick, mid_tick, bit_tick;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Model: cycles elapsed since the current bit phase started.
    bit m_run = 1'b0;
    int m_t = 0;
    int m_n = 1;
    int m_r = 1;
    bit m_os = 1'b0;
    bit m_mid = 1'b0;
    bit m_bit = 1'b0;

    always #5 clk = ~clk;

    uart_baud_gen #(
        .DIV_W  (DIV_W),
        .OS_W   (OS_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div      (div),
        .os_ratio (os_ratio),
`ifdef UART_BAUD_FRAC_EN
        .frac     (frac),
`endif
        .resync   (resync),
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .bit_tick (bit_tick)
    );

    task automatic step();
        int n_in;
        int r_in;
        n_in = (div == '0) ? 1 : int'(div);
        r_in = (os_ratio == '0) ? 1 : int'(os_ratio);
        m_os = 1'b0;
        m_mid = 1'b0;
        m_bit = 1'b0;
        if (!en) begin
            m_run = 1'b0;
        end else if (!m_run || resync) begin
            m_run = 1'b1;
            m_t = 0;
            m_n = n_in;
            m_r = r_in;
        end else begin
            m_t++;
            m_os = (m_t % m_n) == 0;
            m_bit = (m_t == m_n * m_r);
            m_mid = (m_r / 2 == 0) ? m_bit : (m_t == m_n * (m_r / 2));
            if (m_bit) begin
                m_t = 0;
                m_n = n_in;
                m_r = r_in;
            end
        end
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic go_idle();
        en = 1'b0;
        resync = 1'b0;
        step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold got %b%b%b expected 000", os_tick, mid_tick, bit_tick);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            checks++;
            if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
                errors++;
                $display("FAIL idle cycle %0d got %b%b%b expected 000", i, os_tick, mid_tick, bit_tick);
            end
        end
    endtask

    task automatic test_integer_rate();
        int first_os;
        int first_mid;
        int bits[$];
        first_os = -1;
        first_mid = -1;
        go_idle();
        div = 16'd4;
        os_ratio = 5'd16;
        en = 1'b1;
        edge_no = -1;
        while (edge_no < 130) begin
            step();
            checks++;
            if (os_tick !== m_os || mid_tick !== m_mid || bit_tick !== m_bit) begin
                errors++;
                $display("FAIL integer_rate edge %0d got %b%b%b expected %b%b%b",
                         edge_no, os_tick, mid_tick, bit_tick, m_os, m_mid, m_bit);
            end
            if (os_tick === 1'b1 && first_os < 0) first_os = edge_no;
            if (mid_tick === 1'b1 && first_mid < 0) first_mid = edge_no;
            if (bit_tick === 1'b1) bits.push_back(edge_no);
        end
        checks++;
        if (first_os != 4) begin
            errors++;
            $display("FAIL integer_first_os got %0d expected 4", first_os);
        end
        checks++;
        if (first_mid != 32) begin
            errors++;
            $display("FAIL integer_first_mid got %0d expected 32", first_mid);
        end
        checks++;
        if (bits.size() != 2 || bits[0] != 64 || bits[1] != 128) begin
            errors++;
            $display("FAIL integer_bit_edges got %p expected 64,128", bits);
        end
    endtask

    task automatic test_resync();
        int next_os;
        int next_bit;
        next_os = -1;
        next_bit = -1;
        go_idle();
        div = 16'd3;
        os_ratio = 5'd8;
        en = 1'b1;
        edge_no = -1;
        while (edge_no < 80) begin
            resync = (edge_no == 49);
            step();
            resync = 1'b0;
            checks++;
            if (os_tick !== m_os || mid_tick !== m_mid || bit_tick !== m_bit) begin
                errors++;
                $display("FAIL resync edge %0d got %b%b%b expected %b%b%b",
                         edge_no, os_tick, mid_tick, bit_tick, m_os, m_mid, m_bit);
            end
            if (edge_no > 50 && os_tick === 1'b1 && next_os < 0) next_os = edge_no;
            if (edge_no > 50 && bit_tick === 1'b1 && next_bit < 0) next_bit = edge_no;
            if (edge_no == 50) begin
                checks++;
                if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
                    errors++;
                    $display("FAIL resync_quiet got %b%b%b expected 000", os_tick, mid_tick, bit_tick);
                end
            end
        end
        checks++;
        if (next_os != 53) begin
            errors++;
            $display("FAIL resync_next_os got %0d expected 53", next_os);
        end
        checks++;
        if (next_bit != 74) begin
            errors++;
            $display("FAIL resync_next_bit got %0d expected 74", next_bit);
        end
    endtask

    task automatic test_shadow_reload();
        int os_edges[$];
        int exp_edges[$];
        exp_edges = '{4, 8, 12, 16, 18, 20, 22, 24, 26};
        go_idle();
        div = 16'd4;
        os_ratio = 5'd4;
        en = 1'b1;
        edge_no = -1;
        while (edge_no < 27) begin
            if (edge_no == 6) div = 16'd2;
            step();
            checks++;
            if (os_tick !== m_os || mid_tick !== m_mid || bit_tick !== m_bit) begin
                errors++;
                $display("FAIL shadow edge %0d got %b%b%b expected %b%b%b",
                         edge_no, os_tick, mid_tick, bit_tick, m_os, m_mid, m_bit);
            end
            if (os_tick === 1'b1) os_edges.push_back(edge_no);
        end
        checks++;
        if (os_edges != exp_edges) begin
            errors++;
            $display("FAIL shadow_os_edges got %p expected %p", os_edges, exp_edges);
        end
    endtask

    task automatic test_boundary();
        go_idle();
        div = '0;
        os_ratio = '0;
        en = 1'b1;
        edge_no = -1;
        while (edge_no < 20) begin
            step();
            if (edge_no >= 1) begin
                checks++;
                if ({os_tick, mid_tick, bit_tick} !== 3'b111) begin
                    errors++;
                    $display("FAIL zero_cfg edge %0d got %b%b%b expected 111",
                             edge_no, os_tick, mid_tick, bit_tick);
                end
            end
        end
        go_idle();
        div = 16'd5;
        os_ratio = 5'd4;
        en = 1'b1;
        for (int i = 0; i < 11; i++) step();
        en = 1'b0;
        step();
        checks++;
        if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
            errors++;
            $display("FAIL en_drop got %b%b%b expected 000", os_tick, mid_tick, bit_tick);
        end
        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (os_tick !== m_os || mid_tick !== m_mid || bit_tick !== m_bit) begin
                errors++;
                $display("FAIL en_restart cycle %0d got %b%b%b expected %b%b%b",
                         i, os_tick, mid_tick, bit_tick, m_os, m_mid, m_bit);
            end
        end
    endtask

    task automatic test_async_reset();
        int guard;
        go_idle();
        div = 16'd3;
        os_ratio = 5'd4;
        en = 1'b1;
        guard = 0;
        step();
        step();
        while (!m_os && guard < 20) begin
            step();
            guard++;
        end
        #1;
        rst = 1'b0;
        m_run = 1'b0;
        #1;
        checks++;
        if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got %b%b%b expected 000", os_tick, mid_tick, bit_tick);
        end
        #1;
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (os_tick !== m_os || mid_tick !== m_mid || bit_tick !== m_bit) begin
                errors++;
                $display("FAIL after_reset cycle %0d got %b%b%b expected %b%b%b",
                         i, os_tick, mid_tick, bit_tick, m_os, m_mid, m_bit);
            end
        end
    endtask

    task automatic test_random();
        go_idle();
        div = 16'($urandom_range(0, 6));
        os_ratio = 5'($urandom_range(0, 10));
        en = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if (en && $urandom_range(0, 299) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            resync = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 39) == 0) div = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 39) == 0) os_ratio = 5'($urandom_range(0, 10));
            step();
            checks++;
            if (os_tick !== m_os || mid_tick !== m_mid || bit_tick !== m_bit) begin
                errors++;
                $display("FAIL random cycle %0d got %b%b%b expected %b%b%b",
                         i, os_tick, mid_tick, bit_tick, m_os, m_mid, m_bit);
            end
        end
        resync = 1'b0;
    endtask

`ifdef UART_BAUD_FRAC_EN
    task automatic test_fractional();
        int ticks[$];
        int p;
        int prev_p;
        go_idle();
        div = 16'd10;
        os_ratio = 5'd16;
        frac = 4'd8;
        en = 1'b1;
        edge_no = -1;
        while (ticks.size() < 34 && edge_no < 600) begin
            step();
            if (os_tick === 1'b1) ticks.push_back(edge_no);
        end
        checks++;
        if (ticks.size() < 34) begin
            errors++;
            $display("FAIL frac_tick_count got %0d expected 34", ticks.size());
        end else begin
            checks++;
            if (ticks[0] != 10) begin
                errors++;
                $display("FAIL frac_first got %0d expected 10", ticks[0]);
            end
            prev_p = 0;
            for (int i = 1; i < 34; i++) begin
                p = ticks[i] - ticks[i-1];
                checks++;
                if ((p != 10 && p != 11) || (i >= 2 && p == prev_p)) begin
                    errors++;
                    $display("FAIL frac_period %0d got %0d previous %0d expected alternating 10/11", i, p, prev_p);
                end
                prev_p = p;
            end
            checks++;
            if (ticks[33] - ticks[1] != 336) begin
                errors++;
                $display("FAIL frac_span got %0d expected 336", ticks[33] - ticks[1]);
            end
        end
        frac = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_integer_rate();
        test_resync();
        test_shadow_reload();
        test_boundary();
        test_async_reset();
        test_random();
`ifdef UART_BAUD_FRAC_EN
        test_fractional();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised baud/oversample strobe generator for the UART receive and transmit paths. From one system clock it produces single-cycle enable strobes: an oversample tick, a mid-bit sample tick and a bit tick. Divisor and oversample ratio are programmable at runtime. A resync input realigns the bit phase to a detected start-bit edge. It replaces fixed power-of-two derived clocks, so every downstream register stays on `clk` and uses these strobes as enables.

## Interface
- `DIV_W`, 16: width of prescale divisor `div`.
- `OS_W`, 5: width of oversample ratio `os_ratio`.
- `FRAC_W`, 4: width of fractional divisor `frac` (used only with `UART_BAUD_FRAC_EN`).

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; low holds generator idle and cleared.
- `div`  in  DIV_W  prescale divisor N, clk cycles per os_tick; 0 treated as 1.
- `os_ratio`  in  OS_W  oversample ratio R, os_ticks per bit; 0 treated as 1.
- `frac`  in  FRAC_W  fractional divisor F (macro only).
- `resync`  in  1  restart bit phase (RX start-bit alignment).
- `os_tick`  out  1  one-cycle oversample strobe.
- `mid_tick`  out  1  one-cycle strobe at mid-bit.
- `bit_tick`  out  1  one-cycle strobe at end of bit period.

## Operation
- States: IDLE (en=0) and RUN (en=1).
  - IDLE→RUN when en is sampled high.
  - RUN→IDLE when en is sampled low.
- Shadow registers hold N, R and F. They load on the IDLE→RUN edge, on every bit_tick edge, and on resync. Changes on div/os_ratio/frac between loads have no effect.
- Prescale counter pcnt counts 0..N−1. At pcnt=N−1 it wraps to 0 and registers os_tick=1.
- Oversample counter oscnt advances on each os_tick, 0..R−1.
  - bit_tick is asserted with the os_tick that wraps oscnt from R−1 to 0.
  - mid_tick is asserted with the os_tick at oscnt=(R>>1)−1.
  - For R=1, mid_tick equals bit_tick.
- resync while RUN: pcnt and oscnt clear to 0, shadows reload, no strobe that cycle. Phase then restarts exactly as on IDLE→RUN.
- resync while IDLE: ignored.
- resync has priority over the counter wrap in the same cycle.
- en low: at the next edge all counters, the accumulator and all strobes are cleared.
- Counters are unsigned. N−1 and R−1 are computed at DIV_W/OS_W width after 0→1 substitution, so there is no underflow.

## Timing
- Reset value of os_tick, mid_tick and bit_tick: 0. Reset value of pcnt, oscnt and accumulator: 0.
- Take the enabling (or resync) edge as edge 0:
  - first os_tick is high between edges N and N+1;
  - os_tick period is then N (integer mode);
  - first mid_tick is high after edge N·(R>>1);
  - first bit_tick is high after edge N·R, with period N·R.
- All strobes are registered outputs, high exactly one clk cycle. With N=1, os_tick stays high continuously while RUN.
- Asynchronous reset mid-bit clears everything immediately. The first strobe after release follows the edge-0 rule.

## Configuration
- Macro `UART_BAUD_FRAC_EN`.
  - Defined: `frac` port and an FRAC_W-bit accumulator exist. The accumulator adds F at each os_tick. On carry-out, the next prescale period is N+1 instead of N. Mean os_tick period is N+F/2^FRAC_W. The accumulator clears on IDLE, reset and resync.
  - Undefined: no `frac` port, no accumulator, integer periods only.

## Structure
- Package `uart_pkg`: default DIV_W/OS_W/FRAC_W constants, the default oversample ratio constant (16), and the IDLE/RUN state enum.
- Sub-module `uart_prescaler`: pcnt plus optional fractional accumulator, producing os_tick. The top level holds oscnt, the shadows and the mid/bit decode.

## Test plan
- Reset and idle:
  - Stimulus: rst low, then high; en=0 for 100 cycles.
  - Required: all strobes 0, no tick.
- Integer rate:
  - Stimulus: N=4, R=16, en rises at edge 0.
  - Required: os_tick after edges 4, 8, …; mid_tick first after edge 32; bit_tick after edges 64, 128.
- Resync:
  - Stimulus: N=3, R=8; resync pulse at edge 50.
  - Required: next os_tick after edge 53; next bit_tick after edge 74; no strobe at edge 50.
- Shadow reload:
  - Stimulus: change div 4→2 mid-bit.
  - Required: period stays 4 until the bit_tick, then 2.
- Boundary values:
  - N=0,R=0: behaves as N=1,R=1, with os_tick, mid_tick and bit_tick all continuously high.
  - en dropped mid-bit: strobes 0 at the next edge.
- Fractional (macro defined):
  - Stimulus: N=10, F=8, FRAC_W=4.
  - Required: os_tick periods alternate 10, 11; 32 ticks span 336 cycles.
